// File: rtl/n101_i2c_cmd_seq.sv
// n101_i2c_cmd_seq: turns single-byte I2C register commands into Wishbone accesses to the I2C master core.
module n101_i2c_cmd_seq #(
  parameter logic [15:0] PRESCALE = 16'd99,
  parameter logic [15:0] POLL_MAX = 16'd4095
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  input  logic       wbm_ack_i
);
  typedef enum logic [3:0] {INIT, IDLE, TXR, CR, WAIT, POLL, RXR, STO, RSP} state_t;
  state_t      state_q;
  logic [1:0]  phase_q;
  logic        wait_q;
  logic [15:0] poll_q;
  logic        rd_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q, wd_q;
  logic        cmd_ready_q, rsp_valid_q, we_q, stb_q, cyc_q;
  logic [7:0]  rsp_rdata_q, dat_q;
  logic [1:0]  rsp_err_q;
  logic [2:0]  adr_q;
  logic [7:0]  txr, cr, acc_dat;
  logic [2:0]  acc_adr;
  logic        acc_we;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_we_o  = we_q;
  assign wbm_stb_o = stb_q;
  assign wbm_cyc_o = cyc_q;
  // phase 3 is the read-back phase: no TXR byte, CR requests a NACKed read with STOP
  always_comb begin
    txr = phase_q == 2'd0 ? {dev_q, 1'b0} : phase_q == 2'd1 ? reg_q : rd_q ? {dev_q, 1'b1} : wd_q;
    cr  = phase_q == 2'd3 ? 8'h68 : (phase_q == 2'd2 && !rd_q) ? 8'h50 : phase_q == 2'd1 ? 8'h10 : 8'h90;
    acc_adr = state_q == INIT ? (phase_q == 2'd0 ? 3'd0 : phase_q == 2'd1 ? 3'd1 : 3'd2) :
              (state_q == TXR || state_q == RXR) ? 3'd3 : 3'd4;
    acc_dat = state_q == INIT ? (phase_q == 2'd0 ? PRESCALE[7:0] : phase_q == 2'd1 ? PRESCALE[15:8] : 8'h80) :
              state_q == TXR ? txr : state_q == CR ? cr : state_q == STO ? 8'h40 : 8'h00;
    acc_we  = !(state_q == POLL || state_q == RXR);
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= INIT;
      phase_q <= '0;
      wait_q <= 1'b0;
      poll_q <= '0;
      rd_q <= 1'b0;
      dev_q <= '0;
      reg_q <= '0;
      wd_q <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
      we_q <= 1'b0;
      stb_q <= 1'b0;
      cyc_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          rd_q <= cmd_rd;
          dev_q <= cmd_dev;
          reg_q <= cmd_reg;
          wd_q <= cmd_wdata;
          phase_q <= 2'd0;
          cmd_ready_q <= 1'b0;
          state_q <= TXR;
        end
        WAIT: begin
          wait_q <= 1'b1;
          if (wait_q) state_q <= POLL;
        end
        RSP: begin
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= '0;
          rsp_err_q <= '0;
          cmd_ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: if (!cyc_q) begin
          cyc_q <= 1'b1;
          stb_q <= 1'b1;
          adr_q <= acc_adr;
          dat_q <= acc_dat;
          we_q <= acc_we;
        end else if (wbm_ack_i) begin
          cyc_q <= 1'b0;
          stb_q <= 1'b0;
          we_q <= 1'b0;
          case (state_q)
            INIT: begin
              phase_q <= phase_q == 2'd2 ? 2'd0 : phase_q + 2'd1;
              if (phase_q == 2'd2) begin
                cmd_ready_q <= 1'b1;
                state_q <= IDLE;
              end
            end
            TXR: state_q <= CR;
            CR: begin
              wait_q <= 1'b0;
              poll_q <= '0;
              state_q <= WAIT;
            end
            POLL: begin
              poll_q <= poll_q + 16'd1;
              if (!wbm_dat_i[1]) begin
                if (wbm_dat_i[5]) begin
                  rsp_err_q <= 2'b10;
                  rsp_valid_q <= 1'b1;
                  state_q <= RSP;
                end else if (wbm_dat_i[7] && phase_q != 2'd3) begin
                  rsp_err_q <= 2'b01;
                  state_q <= STO;
                end else if (phase_q == 2'd3) begin
                  state_q <= RXR;
                end else if (phase_q == 2'd2 && !rd_q) begin
                  rsp_valid_q <= 1'b1;
                  state_q <= RSP;
                end else begin
                  phase_q <= phase_q + 2'd1;
                  state_q <= phase_q == 2'd2 ? CR : TXR;
                end
              end else if (poll_q == POLL_MAX - 16'd1) begin
                rsp_err_q <= 2'b11;
                state_q <= STO;
              end
            end
            RXR: begin
              rsp_rdata_q <= wbm_dat_i;
              rsp_valid_q <= 1'b1;
              state_q <= RSP;
            end
            STO: begin
              rsp_valid_q <= 1'b1;
              state_q <= RSP;
            end
            default: ;
          endcase
        end
      endcase
    end
  end
endmodule

// File: doc/n101_i2c_cmd_seq.md
Name: n101_i2c_cmd_seq

Overview:
- Wishbone master sequencer sitting directly upstream of the I2C master core's 8-bit register interface.
- Converts single-byte register read/write commands (7-bit device address, 8-bit register address, 8-bit data) into the full core programming sequence: prescale/enable init, TXR/CR writes, status polling and RXR readback.
- Returns a one-beat response carrying read data and an error code.
- Frees the CPU from bit-level polling of the I2C status register.

Parameters:
- PRESCALE, 16'd99, value written to prescale lo/hi registers at init.
- POLL_MAX, 16'd4095, maximum status polls per byte phase before a timeout error.

Ports:
- wb_clk_i  in  1  clock, shared with the I2C core.
- wb_rst_i  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  sequencer idle and able to accept a command.
- cmd_rd  in  1  1 = register read, 0 = register write.
- cmd_dev  in  7  I2C device address.
- cmd_reg  in  8  device register address.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  8  read data; 0 for writes and for errors.
- rsp_err  out  2  00 ok, 01 NACK, 10 arbitration lost, 11 timeout.
- wbm_adr_o  out  3  core register address.
- wbm_dat_o  out  8  write data to the core.
- wbm_dat_i  in  8  read data from the core.
- wbm_we_o  out  1  write enable.
- wbm_stb_o  out  1  strobe.
- wbm_cyc_o  out  1  cycle.
- wbm_ack_i  in  1  core acknowledge.

Behaviour:
- Reset (wb_rst_i sampled high at a clock edge):
  - All outputs go to 0: cmd_ready=0, rsp_valid=0, cyc/stb/we=0, adr=0, dat=0.
  - State goes to INIT. Reset mid-transaction drops cyc/stb on that edge; no response is issued for the aborted command.
- Core register map:
  - Write: 0 PRER lo, 1 PRER hi, 2 CTR, 3 TXR, 4 CR.
  - Read: 3 RXR, 4 SR. SR bits: 7 rxack, 6 busy, 5 al, 1 tip.
- Bus access rules:
  - Drive cyc=stb=1 with adr/we/dat stable until wbm_ack_i=1.
  - Deassert cyc/stb on the edge where ack is seen.
  - Hold at least one idle cycle before the next access.
  - Read data is captured from wbm_dat_i in the ack cycle.
- INIT: write PRER lo = PRESCALE[7:0], PRER hi = PRESCALE[15:8], CTR = 0x80 (core enable, no interrupt), then go to IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch cmd_rd/dev/reg/wdata. cmd_ready drops the next cycle and stays low until the response has been issued.
- Byte phase BYTE(txr, cr):
  - Write TXR = txr, write CR = cr.
  - Wait 2 idle cycles so the core's tip flag is valid.
  - Read SR repeatedly until tip=0.
  - Then check error bits in priority order: al=1 gives err 10; else rxack=1 on a write phase gives err 01.
  - A poll counter is cleared at the start of each phase; if it reaches POLL_MAX without tip=0, the result is err 11.
- Write command sequence:
  - BYTE({dev,0}, 0x90 STA|WR)
  - BYTE(reg, 0x10 WR)
  - BYTE(wdata, 0x50 STO|WR)
- Read command sequence:
  - BYTE({dev,0}, 0x90)
  - BYTE(reg, 0x10)
  - BYTE({dev,1}, 0x90, repeated start)
  - RD phase: write CR = 0x68 (STO|RD|ACK = master NACK), wait 2 cycles, poll tip, then read RXR.
  - rxack is ignored in the RD phase.
- Errors:
  - On err 01 or 11, write CR = 0x40 (STO), then respond.
  - On err 10, respond immediately without STO (the core has already released the bus).
  - Remaining phases are skipped.
- Response:
  - rsp_valid is high for exactly 1 cycle, together with rsp_rdata/rsp_err.
  - Return to IDLE the next cycle.
  - The response is not back-pressured.
- A cmd_valid arriving while busy is ignored; no queueing.

Test Plan:
- Reset release with ack in the cycle after each stb -> exactly 3 writes (adr0=0x63, adr1=0x00, adr2=0x80), then cmd_ready=1.
- Write dev=0x50, reg=0x12, data=0xA5 with all SR polls returning 0x00 -> TXR/CR pairs (0xA0,0x90), (0x12,0x10), (0xA5,0x50); rsp_valid 1 cycle, err=00, rdata=0x00.
- Read dev=0x50, reg=0x12 with RXR returning 0x3C -> TXR 0xA0, 0x12, 0xA1; CR 0x90, 0x10, 0x90, 0x68; response rdata=0x3C, err=00.
- NACK: first-phase SR returns 0x80 -> CR 0x40 written, err=01, no later TXR writes.
- Arbitration lost: SR returns 0x20 -> err=10, no CR=0x40 write.
- Timeout and reset:
  - SR stuck at 0x02 with POLL_MAX=8 -> 8 polls, CR=0x40, err=11.
  - Reset asserted mid-poll -> cyc/stb=0 next edge, INIT sequence reissued, no rsp_valid.
